audio_zc_monitor: RTL

//  In-design per-channel monitor fed by the codec output samples (aout_lft/aout_rht strobes).
//  - Detects negative->positive zero crossings.
//  - Measures the period (in samples) and positive peak of each cycle.
//  - Flags any period or amplitude outside programmed windows.
//  - Instantiate once per channel. The status feeds LEDs and the on-chip self-test.

---
 rtl/audio_zc_monitor.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/audio_zc_monitor.sv
// audio_zc_monitor: per-channel zero-crossing monitor measuring period and positive peak of codec samples.
// Define ZC_HYST_EN to qualify crossings with a -HYST arming threshold instead of a plain sign flip.
module audio_zc_monitor #(
  parameter int SETTLE_XINGS = 10,
  parameter int NUM_MEAS     = 2000,
  parameter int MIN_AMPL     = 2500,
  parameter int MAX_AMPL     = 17000,
  parameter int MIN_PER      = 12,
  parameter int MAX_PER      = 20,
  parameter int HYST         = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        smpl_vld,
  input  logic [15:0] smpl,
  output logic        busy,
  output logic        done,
  output logic        meas_vld,
  output logic [7:0]  period,
  output logic [15:0] peak,
  output logic [15:0] ampl_errs,
  output logic [15:0] freq_errs
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, MEASURE = 2'd2, DONE = 2'd3} state_t;

  localparam logic signed [15:0] MIN_A    = 16'(MIN_AMPL);
  localparam logic signed [15:0] MAX_A    = 16'(MAX_AMPL);
  localparam logic [7:0]         MIN_P    = 8'(MIN_PER);
  localparam logic [7:0]         MAX_P    = 8'(MAX_PER);
  localparam logic [15:0]        SETTLE_N = 16'(SETTLE_XINGS);
  localparam logic [15:0]        MEAS_N   = 16'(NUM_MEAS);

  state_t             state;
  logic signed [15:0] s;
  logic signed [15:0] pk;
  logic [7:0]         cnt;
  logic [15:0]        xings;
  logic [15:0]        meas_cnt;
  logic               xing;

  assign s = smpl;

`ifdef ZC_HYST_EN
  logic armed;

  assign xing = smpl_vld && armed && !s[15];

  // Arm on a sufficiently negative sample; a qualified crossing or start disarms.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed <= 1'b0;
    end else if (start) begin
      armed <= 1'b0;
    end else if (smpl_vld) begin
      if (xing) begin
        armed <= 1'b0;
      end else if (int'(s) <= -HYST) begin
        armed <= 1'b1;
      end
    end
  end
`else
  localparam int hyst_unused = HYST;
  logic signed [15:0] prev;

  assign xing = smpl_vld && prev[15] && !s[15];

  // Previous sample follows every valid strobe regardless of state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= 16'sd0;
    end else if (smpl_vld) begin
      prev <= s;
    end
  end
`endif

  // Control FSM with window tracking and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      meas_vld  <= 1'b0;
      period    <= 8'd0;
      peak      <= 16'd0;
      ampl_errs <= 16'd0;
      freq_errs <= 16'd0;
      cnt       <= 8'd0;
      pk        <= 16'sd0;
      xings     <= 16'd0;
      meas_cnt  <= 16'd0;
    end else begin
      meas_vld <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else if (start) begin
        state     <= SETTLE;
        busy      <= 1'b1;
        done      <= 1'b0;
        period    <= 8'd0;
        peak      <= 16'd0;
        ampl_errs <= 16'd0;
        freq_errs <= 16'd0;
        cnt       <= 8'd0;
        pk        <= 16'sd0;
        xings     <= 16'd0;
        meas_cnt  <= 16'd0;
      end else if (smpl_vld && (state == SETTLE || state == MEASURE)) begin
        if (xing) begin
          // The crossing sample closes the old window and is the first of the new one.
          cnt <= 8'd1;
          pk  <= s;
          if (state == SETTLE) begin
            xings <= xings + 16'd1;
            if (xings + 16'd1 == SETTLE_N) begin
              state <= MEASURE;
            end
          end else begin
            period   <= cnt;
            peak     <= pk;
            meas_vld <= 1'b1;
            if ((pk < MIN_A || pk > MAX_A) && ampl_errs != 16'hFFFF) begin
              ampl_errs <= ampl_errs + 16'd1;
            end
            if ((cnt < MIN_P || cnt > MAX_P) && freq_errs != 16'hFFFF) begin
              freq_errs <= freq_errs + 16'd1;
            end
            meas_cnt <= meas_cnt + 16'd1;
            if (meas_cnt + 16'd1 == MEAS_N) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end else begin
          if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
          if (s > pk) begin
            pk <= s;
          end
        end
      end
    end
  end

endmodule
